// File: rtl/order_25d_sched.sv
// order_25d_sched: round-robin front end for one shared 25-element sort datapath.
// Two requesters share the datapath. A source tag travels with each frame, and
// results are collected in an output FIFO. Issue is credit-based, so every
// frame that is issued always has a FIFO slot waiting for it.
// Optional performance counters are enabled with `define ORDER_25D_SCHED_PERF_EN.
module order_25d_sched #(
    parameter int DSIZE = 64,
    parameter int NUM   = 25,
    parameter int LAT   = 1,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [NUM*DSIZE-1:0]   req0_data,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [NUM*DSIZE-1:0]   req1_data,
    output logic [NUM*DSIZE-1:0]   sort_id,
    output logic                   sort_issue,
    input  logic [NUM*DSIZE-1:0]   sort_od,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM*DSIZE-1:0]   out_data,
    output logic                   out_src,
    input  logic                   flush,
    output logic                   flush_done,
    output logic                   busy
`ifdef ORDER_25D_SCHED_PERF_EN
    ,
    output logic [31:0]            perf_stall,
    output logic [31:0]            perf_frames0,
    output logic [31:0]            perf_frames1
`endif
);

    localparam int FW = NUM * DSIZE;
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [OW-1:0]   occ;
    logic            rr;
    logic            flush_seen;
    logic [LAT-1:0]  tag_v;
    logic [LAT-1:0]  tag_src;

    logic [FW-1:0]   fifo_mem [DEPTH];
    logic [DEPTH-1:0] fifo_src;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [OW-1:0]   count;

    logic            can_issue;
    logic            grant0;
    logic            grant1;
    logic            issue;
    logic            push;
    logic            pop;

    // The credit check uses the registered occupancy only. A pop cannot free a
    // slot in the same cycle, so out_ready has no path to the ready outputs.
    assign can_issue = ((state == IDLE) || (state == RUN)) && !flush && (occ < OW'(DEPTH));
    assign grant0    = can_issue && req0_valid && (!req1_valid || !rr);
    assign grant1    = can_issue && req1_valid && (!req0_valid || rr);
    assign issue     = grant0 || grant1;

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign sort_issue = issue;
    assign sort_id    = grant0 ? req0_data : (grant1 ? req1_data : '0);

    assign push      = tag_v[LAT-1];
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;
    assign out_src   = out_valid ? fifo_src[rd_ptr] : 1'b0;

    assign busy       = (occ != '0);
    assign flush_done = (state == DONE);

    // The round-robin pointer moves only when both requesters are competing.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr <= 1'b0;
        end else if (issue && req0_valid && req1_valid) begin
            rr <= ~rr;
        end
    end

    // Occupancy counts frames in the tag pipe plus frames held in the FIFO.
    always_ff @(posedge clock) begin
        if (reset) begin
            occ <= '0;
        end else if (issue && !pop) begin
            occ <= occ + OW'(1);
        end else if (pop && !issue) begin
            occ <= occ - OW'(1);
        end
    end

    // The tag pipe matches the datapath latency, so its tail marks a valid result.
    always_ff @(posedge clock) begin
        if (reset) begin
            tag_v   <= '0;
            tag_src <= '0;
        end else begin
            tag_v[0]   <= issue;
            tag_src[0] <= grant1;
            for (int i = 1; i < LAT; i++) begin
                tag_v[i]   <= tag_v[i-1];
                tag_src[i] <= tag_src[i-1];
            end
        end
    end

    // The FIFO data array has no reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= sort_od;
        end
    end

    // FIFO pointers, count and source bits. When full, a push and pop together
    // overwrite the slot being popped.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            fifo_src <= '0;
        end else begin
            if (push) begin
                fifo_src[wr_ptr] <= tag_src[LAT-1];
                wr_ptr           <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + OW'(1);
            end else if (pop && !push) begin
                count <= count - OW'(1);
            end
        end
    end

    // Marks a flush already acknowledged, so a held flush does not pulse flush_done again.
    always_ff @(posedge clock) begin
        if (reset) begin
            flush_seen <= 1'b0;
        end else if (!flush) begin
            flush_seen <= 1'b0;
        end else if (state == DONE) begin
            flush_seen <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic for the issue/drain sequencing.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (flush && !flush_seen) begin
                    state_next = DONE;
                end else if (issue) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_next = DRAIN;
                end else if ((occ == '0) && !issue) begin
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                if (occ == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef ORDER_25D_SCHED_PERF_EN
    logic stall_cond;

    assign stall_cond = (req0_valid || req1_valid) && (occ == OW'(DEPTH));

    // Saturating counters: credit stalls and frames issued per requester. Flush does not clear them.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_stall   <= '0;
            perf_frames0 <= '0;
            perf_frames1 <= '0;
        end else begin
            if (stall_cond && (perf_stall != 32'hFFFF_FFFF)) begin
                perf_stall <= perf_stall + 32'd1;
            end
            if (grant0 && (perf_frames0 != 32'hFFFF_FFFF)) begin
                perf_frames0 <= perf_frames0 + 32'd1;
            end
            if (grant1 && (perf_frames1 != 32'hFFFF_FFFF)) begin
                perf_frames1 <= perf_frames1 + 32'd1;
            end
        end
    end
`endif

endmodule
